enc_dec_pipe: RTL and testbench
===============================

ENC_DEC_PIPE -- requirements
Module: enc_dec_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits; legal range 2..64.
REQ-002 SHALL have parameter PRIORITY_HIGH, default 1: 1 = highest set bit wins, 0 = lowest set bit wins.
REQ-003 SHALL derive localparam IDXW = clog2(WIDTH), minimum 1.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  word to encode.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_data  output  WIDTH  decoded one-hot word.
REQ-013 out_idx  output  IDXW  encoded index of winning bit.
REQ-014 out_good  output  1  at least one in_data bit was set.
REQ-015 out_match  output  1  out_data equals the original in_data.
REQ-016 err_clr  input  1  clears err_count (present only with macro, REQ-036).
REQ-017 err_count  output  8  saturating mismatch count (present only with macro).

Function
REQ-018 SHALL transfer input when in_valid && in_ready; output when out_valid && out_ready.
REQ-019 SHALL be a two-stage pipeline: S1 = encode, S2 = decode/compare.
REQ-020 S1 SHALL register idx = position of winning set bit per PRIORITY_HIGH, good = |in_data, and the original word.
REQ-021 S1 idx SHALL be 0 when in_data == 0 (good = 0).
REQ-022 S2 SHALL register out_data = (1 << idx) if good else 0, out_idx, out_good, and out_match = (out_data == original word).
REQ-023 Each stage SHALL load when it is empty or its contents move downstream this cycle; otherwise it holds.
REQ-024 in_ready SHALL be !s1_valid || (S1 moves to S2 this cycle); combinational path out_ready -> in_ready is permitted.
REQ-025 Latency SHALL be exactly 2 cycles from input transfer to out_valid with out_ready held high.
REQ-026 Throughput SHALL be one word per cycle with out_ready held high.
REQ-027 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-028 Simultaneous output transfer and new S1 load SHALL lose no word and duplicate none.
REQ-029 Pipeline full (both stages valid, out_ready = 0) SHALL drive in_ready = 0.
REQ-030 Words SHALL leave in acceptance order.

Reset
REQ-031 On clk edge with rst_n = 0: s1_valid, out_valid = 0; out_data, out_idx, out_good, out_match = 0; err_count = 0.
REQ-032 in_ready SHALL read 1 in the first cycle after reset release.
REQ-033 Reset mid-operation SHALL discard all in-flight words; none emerge afterward.

Configuration
REQ-034 Macro ENC_DEC_ERRCNT_EN SHALL control the mismatch counter.
REQ-035 Without it: no err_clr/err_count ports, no counter logic; all other behaviour identical.
REQ-036 With it: err_count increments by 1 on each output transfer with out_match = 0, saturates at 255.
REQ-037 With it: err_clr = 1 sets err_count to 0 next edge; clear wins over a simultaneous increment.

Verification
REQ-038 WIDTH=8, PRIORITY_HIGH=1, in_data=8'b0001_0000, out_ready=1 -> 2 cycles later out_data=8'h10, out_idx=4, out_good=1, out_match=1.
REQ-039 WIDTH=8, PRIORITY_HIGH=1, in_data=8'h05 -> out_idx=2, out_data=8'h04, out_match=0; PRIORITY_HIGH=0 -> out_idx=0, out_data=8'h01.
REQ-040 in_data=8'h00 -> out_good=0, out_idx=0, out_data=8'h00, out_match=1.
REQ-041 Stream 8'h01,8'h02,8'h04, out_ready low 3 cycles after first output -> in_ready=0 while full, outputs held, order 01,02,04 preserved, none lost.
REQ-042 Macro on: 300 transfers of 8'h03 -> err_count=255; err_clr with simultaneous mismatch transfer -> err_count=0.
REQ-043 rst_n low one cycle with both stages full -> next cycle out_valid=0, in_ready=1, no stale word emerges.

Source files
------------

// File: rtl/enc_dec_pipe.sv
// rtl/enc_dec_pipe.sv - two-stage priority encode / one-hot decode pipeline with compare
// Optional saturating mismatch counter built when ENC_DEC_ERRCNT_EN is defined.
module enc_dec_pipe #(
   parameter int WIDTH = 8,
   parameter int PRIORITY_HIGH = 1,
   localparam int IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [IDXW-1:0] out_idx,
   output logic            out_good,
   output logic            out_match
`ifdef ENC_DEC_ERRCNT_EN
   ,
   input  logic            err_clr,
   output logic [7:0]      err_count
`endif
);

   logic             s1_valid;
   logic [IDXW-1:0]  s1_idx;
   logic             s1_good;
   logic [WIDTH-1:0] s1_word;
   logic [IDXW-1:0]  enc_idx;
   logic [WIDTH-1:0] dec_data;
   logic             s2_load;

   // The scan order decides which set bit is kept: the last hit overwrites earlier ones.
   always_comb begin
      enc_idx = '0;
      if (PRIORITY_HIGH != 0) begin
         for (int i = 0; i < WIDTH; i++)
            if (in_data[i]) enc_idx = IDXW'(i);
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--)
            if (in_data[i]) enc_idx = IDXW'(i);
      end
   end

   assign dec_data = s1_good ? (WIDTH'(1) << s1_idx) : '0;
   assign s2_load  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_load;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_idx    <= '0;
         s1_good   <= 1'b0;
         s1_word   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_good  <= 1'b0;
         out_match <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_idx  <= enc_idx;
               s1_good <= |in_data;
               s1_word <= in_data;
            end
         end
         if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data  <= dec_data;
               out_idx   <= s1_idx;
               out_good  <= s1_good;
               out_match <= (dec_data == s1_word);
            end
         end
      end
   end

`ifdef ENC_DEC_ERRCNT_EN
   // Clear takes priority over an increment landing on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n || err_clr)
         err_count <= 8'd0;
      else if (out_valid && out_ready && !out_match && err_count != 8'hff)
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_enc_dec_pipe.sv
// tb/tb_enc_dec_pipe.sv - scoreboard bench for enc_dec_pipe, both priority modes side by side
module tb_enc_dec_pipe;

   typedef struct {
      logic [7:0] word;
      logic       good;
      logic [2:0] hi_idx;
      logic [7:0] hi_data;
      logic       hi_match;
      logic [2:0] lo_idx;
      logic [7:0] lo_data;
      logic       lo_match;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_idx;
   logic       out_good;
   logic       out_match;
   logic       lo_in_ready;
   logic       lo_valid;
   logic [7:0] lo_data;
   logic [2:0] lo_idx;
   logic       lo_good;
   logic       lo_match;
`ifdef ENC_DEC_ERRCNT_EN
   logic       err_clr;
   logic [7:0] err_count;
   logic [7:0] lo_err_count;
`endif

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   enc_dec_pipe #(.WIDTH(8), .PRIORITY_HIGH(1)) u_hi (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
      .out_good(out_good), .out_match(out_match)
`ifdef ENC_DEC_ERRCNT_EN
      , .err_clr(err_clr), .err_count(err_count)
`endif
   );

   enc_dec_pipe #(.WIDTH(8), .PRIORITY_HIGH(0)) u_lo (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(lo_in_ready), .in_data(in_data),
      .out_valid(lo_valid), .out_ready(out_ready), .out_data(lo_data), .out_idx(lo_idx),
      .out_good(lo_good), .out_match(lo_match)
`ifdef ENC_DEC_ERRCNT_EN
      , .err_clr(err_clr), .err_count(lo_err_count)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Hand-computed results: {word, good, hi idx/data/match, lo idx/data/match}
   function automatic exp_t exp_of(input logic [7:0] d);
      exp_t e;
      case (d)
         8'h10:   e = '{8'h10, 1'b1, 3'd4, 8'h10, 1'b1, 3'd4, 8'h10, 1'b1};
         8'h05:   e = '{8'h05, 1'b1, 3'd2, 8'h04, 1'b0, 3'd0, 8'h01, 1'b0};
         8'h00:   e = '{8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b1};
         8'h01:   e = '{8'h01, 1'b1, 3'd0, 8'h01, 1'b1, 3'd0, 8'h01, 1'b1};
         8'h02:   e = '{8'h02, 1'b1, 3'd1, 8'h02, 1'b1, 3'd1, 8'h02, 1'b1};
         8'h04:   e = '{8'h04, 1'b1, 3'd2, 8'h04, 1'b1, 3'd2, 8'h04, 1'b1};
         8'h08:   e = '{8'h08, 1'b1, 3'd3, 8'h08, 1'b1, 3'd3, 8'h08, 1'b1};
         8'h80:   e = '{8'h80, 1'b1, 3'd7, 8'h80, 1'b1, 3'd7, 8'h80, 1'b1};
         8'hff:   e = '{8'hff, 1'b1, 3'd7, 8'h80, 1'b0, 3'd0, 8'h01, 1'b0};
         8'h03:   e = '{8'h03, 1'b1, 3'd1, 8'h02, 1'b0, 3'd0, 8'h01, 1'b0};
         8'ha5:   e = '{8'ha5, 1'b1, 3'd7, 8'h80, 1'b0, 3'd0, 8'h01, 1'b0};
         default: e = '{d, 1'bx, 3'bx, 8'bx, 1'bx, 3'bx, 8'bx, 1'bx};
      endcase
      return e;
   endfunction

   // Called at a falling edge; returns at the falling edge after the word was accepted.
   task automatic send(input logic [7:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("send_accept", {63'd0, in_ready}, 64'd1);
      q.push_back(exp_of(d));
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   logic       held = 1'b0;
   logic [7:0] h_data;
   logic [2:0] h_idx;
   logic       h_good;
   logic       h_match;

   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held)
            chk("stall_hold", {51'd0, out_valid, out_data, out_idx, out_good, out_match},
                {51'd0, 1'b1, h_data, h_idx, h_good, h_match});
         held = 1'b0;
         if (out_valid && !out_ready) begin
            held = 1'b1;
            {h_data, h_idx, h_good, h_match} = {out_data, out_idx, out_good, out_match};
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_output", {56'd0, out_data}, 64'hdead);
            end else begin
               e = q.pop_front();
               chk("hi_data",  {56'd0, out_data}, {56'd0, e.hi_data});
               chk("hi_idx",   {61'd0, out_idx}, {61'd0, e.hi_idx});
               chk("hi_good",  {63'd0, out_good}, {63'd0, e.good});
               chk("hi_match", {63'd0, out_match}, {63'd0, e.hi_match});
               chk("lo_valid", {63'd0, lo_valid}, 64'd1);
               chk("lo_data",  {56'd0, lo_data}, {56'd0, e.lo_data});
               chk("lo_idx",   {61'd0, lo_idx}, {61'd0, e.lo_idx});
               chk("lo_good",  {63'd0, lo_good}, {63'd0, e.good});
               chk("lo_match", {63'd0, lo_match}, {63'd0, e.lo_match});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] stream [9];
      int t0;
      int n;
      stream = '{8'h05, 8'h00, 8'h01, 8'h02, 8'h04, 8'h80, 8'hff, 8'h03, 8'ha5};
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      out_ready = 1'b1;
`ifdef ENC_DEC_ERRCNT_EN
      err_clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_word", {52'd0, out_data, out_idx, out_good, out_match}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_in_ready", {62'd0, in_ready, lo_in_ready}, 64'd3);

      // Latency: accepted word visible two edges later
      in_valid = 1'b1;
      in_data = 8'h10;
      #1;
      chk("lat_accept", {63'd0, in_ready}, 64'd1);
      q.push_back(exp_of(8'h10));
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("lat_cycle1", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      #1;
      chk("lat_cycle2", {63'd0, out_valid}, 64'd1);
      @(negedge clk);

      t0 = cyc;
      foreach (stream[i]) send(stream[i]);
      in_valid = 1'b0;
      chk("throughput", 64'(cyc - t0), 64'd9);
      drain();

      // Back-pressure with the pipeline full
      send(8'h01);
      send(8'h02);
      send(8'h04);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h08;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("full_in_ready", {63'd0, in_ready}, 64'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_in_ready", {63'd0, in_ready}, 64'd1);
      q.push_back(exp_of(8'h08));
      @(negedge clk);
      in_valid = 1'b0;
      drain();

      // Reset with both stages occupied
      out_ready = 1'b0;
      send(8'h80);
      send(8'hff);
      in_valid = 1'b0;
      #1;
      chk("pre_reset_full", {62'd0, out_valid, in_ready}, 64'd2);
      rst_n = 1'b0;
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_reset_valid", {63'd0, out_valid}, 64'd0);
      chk("post_reset_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      repeat (6) @(negedge clk);

`ifdef ENC_DEC_ERRCNT_EN
      chk("err_after_reset", {56'd0, err_count}, 64'd0);
      for (int i = 0; i < 300; i++) send(8'h03);
      in_valid = 1'b0;
      drain();
      chk("err_saturate", {56'd0, err_count}, 64'd255);
      send(8'h03);
      in_valid = 1'b0;
      n = 0;
      #1;
      while (!out_valid && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("err_clr_window", {63'd0, out_valid}, 64'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      chk("err_clr_wins", {56'd0, err_count}, 64'd0);
`endif

      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
